fetch_pc_unit: RTL and testbench



---
 rtl/core_types_pkg.sv | 30 +++
 rtl/fetch_skid_buffer.sv | 42 ++++
 rtl/fetch_pc_unit.sv | 146 ++++++++++++++
 tb/tb_fetch_pc_unit.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: branching-unit control bundle, fetch FSM states and
// fetch constants used by the instruction-fetch stage.
package core_types_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

    typedef struct packed {
        logic        flush;
        logic        hold;
        logic        bypass;
        logic        branch;
        logic [31:0] PCnext;
        logic [31:0] PCcurrent;
    } branching_out_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    // Absolute on bypass, PC-relative on branch; always word aligned.
    function automatic logic [31:0] fetch_target(input branching_out_t b);
        logic [31:0] t;
        t = b.bypass ? b.PCnext : (b.PCcurrent + b.PCnext);
        return t & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry {PC, instr} holding register for a response that returns while
// decode is held. Clear beats load; load beats drain so refill-on-drain keeps it full.
module fetch_skid_buffer
    import core_types_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        full_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        full_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q  <= 1'b0;
            pc_q    <= 32'h0;
            instr_q <= NOP_INSTR;
        end else if (clear_i) begin
            full_q  <= 1'b0;
        end else if (load_i) begin
            full_q  <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (drain_i) begin
            full_q  <= 1'b0;
        end
    end

    assign full_o  = full_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues single-outstanding imem requests
// and fills the IF/DEC register, with a one-entry skid buffer for held decode.
module fetch_pc_unit
    import core_types_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic           Clock,
    input  logic           Reset,
    input  branching_out_t branching_out,
    output logic           imem_req,
    output logic [31:0]    imem_addr,
    input  logic           imem_gnt,
    input  logic           imem_rvalid,
    input  logic [31:0]    imem_rdata,
    output logic [31:0]    PCIF,
    output logic [31:0]    instrDEC,
    output logic           validDEC
);

    fetch_state_t state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic [31:0]  req_pc_q, req_pc_d;
    logic         outstanding_q, outstanding_d;
    logic [31:0]  pcif_q, pcif_d;
    logic [31:0]  instr_q, instr_d;
    logic         valid_q, valid_d;

    logic         redirect;
    logic [31:0]  target;
    logic         grant;
    logic         resp_live;
    logic         resp_take;
    logic         skid_full;
    logic         skid_load;
    logic         skid_drain;
    logic         skid_clear;
    logic [31:0]  skid_pc;
    logic [31:0]  skid_instr;

    assign redirect  = branching_out.bypass | branching_out.branch;
    assign target    = fetch_target(branching_out);
    assign resp_live = imem_rvalid && outstanding_q;
    assign resp_take = resp_live && (state_q == FETCH);
    assign grant     = imem_req && imem_gnt;

    // Request depends only on state, registers and the memory handshake.
    assign imem_req  = (state_q == FETCH) && !skid_full && (!outstanding_q || imem_rvalid);
    assign imem_addr = fetch_pc_q;

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        pcif_d        = pcif_q;
        instr_d       = instr_q;
        valid_d       = valid_q;
        skid_load     = 1'b0;
        skid_drain    = 1'b0;
        skid_clear    = 1'b0;
        outstanding_d = grant | (outstanding_q & ~imem_rvalid);

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = FETCH;
            DRAIN:   if (resp_live) state_d = FETCH;
            default: state_d = IDLE;
        endcase

        if (grant) begin
            req_pc_d   = fetch_pc_q;
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (redirect) begin
            fetch_pc_d = target;
            valid_d    = 1'b0;
            skid_clear = 1'b1;
            state_d    = outstanding_d ? DRAIN : FETCH;
        end else if (branching_out.flush) begin
            valid_d    = 1'b0;
            skid_clear = 1'b1;
        end else if (branching_out.hold) begin
            if (resp_take) begin
                // Nowhere to park a second word: drop it and refetch it later.
                if (skid_full) begin
                    fetch_pc_d = req_pc_q;
                end else begin
                    skid_load = 1'b1;
                end
            end
        end else begin
            if (skid_full) begin
                pcif_d     = skid_pc;
                instr_d    = skid_instr;
                valid_d    = 1'b1;
                skid_drain = 1'b1;
                skid_load  = resp_take;
            end else if (resp_take) begin
                pcif_d  = req_pc_q;
                instr_d = imem_rdata;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            pcif_q        <= 32'h0;
            instr_q       <= NOP_INSTR;
            valid_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            pcif_q        <= pcif_d;
            instr_q       <= instr_d;
            valid_q       <= valid_d;
        end
    end

    fetch_skid_buffer u_skid (
        .clk_i   (Clock),
        .rst_i   (Reset),
        .clear_i (skid_clear),
        .load_i  (skid_load),
        .drain_i (skid_drain),
        .pc_i    (req_pc_q),
        .instr_i (imem_rdata),
        .full_o  (skid_full),
        .pc_o    (skid_pc),
        .instr_o (skid_instr)
    );

    assign PCIF     = pcif_q;
    assign instrDEC = instr_q;
    assign validDEC = valid_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench: a memory model answers requests, a stream model predicts the
// in-order PC sequence decode must see, and a monitor compares each new IF/DEC entry.
module tb_fetch_pc_unit;
    import core_types_pkg::*;

    logic           Clock = 1'b0;
    logic           Reset;
    branching_out_t branching_out;
    logic           imem_req;
    logic [31:0]    imem_addr;
    logic           imem_gnt;
    logic           imem_rvalid;
    logic [31:0]    imem_rdata;
    logic [31:0]    PCIF;
    logic [31:0]    instrDEC;
    logic           validDEC;

    always #5 Clock = ~Clock;

    fetch_pc_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clock         (Clock),
        .Reset         (Reset),
        .branching_out (branching_out),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .PCIF          (PCIF),
        .instrDEC      (instrDEC),
        .validDEC      (validDEC)
    );

    int checks = 0;
    int errors = 0;
    int delivered = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- memory model ----------------
    typedef struct {
        logic [31:0] addr;
        int          due;
    } resp_t;
    resp_t mem_q[$];
    int    cyc     = 0;
    int    lat_min = 1;
    int    lat_max = 1;
    int    gnt_pct = 100;

    initial begin
        logic        g;
        logic        rv;
        logic [31:0] a;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge Clock);
            g  = imem_req && imem_gnt;
            a  = imem_addr;
            rv = imem_rvalid;
            if (imem_req) check32("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
            @(posedge Clock);
            cyc++;
            if (rv && mem_q.size() > 0) void'(mem_q.pop_front());
            if (g) mem_q.push_back('{a, cyc + int'($urandom_range(lat_max, lat_min))});
            #2;
            if (mem_q.size() > 0 && mem_q[0].due <= cyc + 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_q[0].addr);
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = $urandom;
            end
            imem_gnt = (int'($urandom_range(99, 0)) < gnt_pct);
        end
    end

    // ---------------- instruction-stream model ----------------
    typedef struct {
        logic [31:0] pc;
        bit          opt;
    } exp_t;
    exp_t exp_q[$];
    bit   last_hold   = 1'b0;
    int   since_redir = 100;

    function automatic void restart(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back('{start + 32'(4 * i), 1'b0});
    endfunction

    initial begin
        logic [31:0] t;
        forever begin
            @(posedge Clock);
            since_redir++;
            if (Reset) begin
                restart(32'h0);
                last_hold   = 1'b0;
                since_redir = 100;
            end else if (branching_out.bypass || branching_out.branch) begin
                t = branching_out.bypass ? branching_out.PCnext
                                         : branching_out.PCcurrent + branching_out.PCnext;
                t[1:0] = 2'b00;
                restart(t);
                last_hold   = 1'b0;
                since_redir = 0;
            end else if (branching_out.flush) begin
                // Up to two not-yet-seen words (skid + in-flight) may be discarded.
                for (int i = 0; i < 2 && i < exp_q.size(); i++) exp_q[i].opt = 1'b1;
                last_hold = 1'b0;
            end else begin
                last_hold = branching_out.hold;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge Clock);
            if (since_redir < 2) check32("valid_low_after_redirect", 32'(validDEC), 32'd0);
            if (validDEC && !last_hold) begin
                delivered++;
                while (exp_q.size() > 1 && exp_q[0].opt && exp_q[0].pc != PCIF)
                    void'(exp_q.pop_front());
                check32("dec_pc", PCIF, exp_q[0].pc);
                check32("dec_instr", instrDEC, mem_word(exp_q[0].pc));
                void'(exp_q.pop_front());
                while (exp_q.size() < 16) exp_q.push_back('{exp_q[$].pc + 32'd4, 1'b0});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    task automatic wait_req_addr(input string name, input logic [31:0] exp);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge Clock);
            if (imem_req) begin
                seen = 1'b1;
                check32(name, imem_addr, exp);
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s: no imem_req within 40 cycles, required addr %h", name, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check32({tag, "_req"},   32'(imem_req), 32'd0);
        check32({tag, "_addr"},  imem_addr,     32'h0);
        check32({tag, "_pcif"},  PCIF,          32'h0);
        check32({tag, "_instr"}, instrDEC,      NOP_INSTR);
        check32({tag, "_valid"}, 32'(validDEC), 32'd0);
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] a;
        int unsigned r;
        int          hold_left;
        bit          found;

        Reset         = 1'b1;
        branching_out = '0;
        repeat (3) @(posedge Clock);
        #1;
        check_reset_outputs("reset");
        Reset = 1'b0;

        // First request one cycle after IDLE, first decode word two cycles later.
        @(negedge Clock); check32("lat_req_idle", 32'(imem_req), 32'd0);
        @(negedge Clock); check32("lat_req_first", 32'(imem_req), 32'd1);
        check32("lat_addr_first", imem_addr, 32'h0);
        @(negedge Clock); check32("lat_valid_early", 32'(validDEC), 32'd0);
        @(negedge Clock); check32("lat_valid_first", 32'(validDEC), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge Clock); check32("throughput_valid", 32'(validDEC), 32'd1);
        end

        // Branch while a slow response is outstanding.
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge Clock);
            if (!imem_req && !imem_rvalid) found = 1'b1;
        end
        check32("branch_setup_outstanding", 32'(found), 32'd1);
        branching_out.branch    = 1'b1;
        branching_out.PCcurrent = 32'h100;
        branching_out.PCnext    = 32'h20;
        @(posedge Clock); #1;
        branching_out = '0;
        @(negedge Clock);
        check32("branch_drain_state", 32'(dut.state_q), 32'(DRAIN));
        check32("branch_drain_noreq", 32'(imem_req), 32'd0);
        wait_req_addr("branch_target_addr", 32'h120);
        repeat (10) @(negedge Clock);

        // Bypass ignores PCcurrent and aligns the target.
        lat_min = 1; lat_max = 1;
        repeat (4) @(negedge Clock);
        branching_out.bypass    = 1'b1;
        branching_out.PCnext    = 32'h203;
        branching_out.PCcurrent = $urandom;
        @(posedge Clock); #1;
        branching_out = '0;
        wait_req_addr("bypass_target_addr", 32'h200);
        repeat (8) @(negedge Clock);

        // Three-cycle hold during zero-wait streaming.
        @(negedge Clock);
        p = PCIF;
        check32("hold_pre_valid", 32'(validDEC), 32'd1);
        branching_out.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            check32("hold_pcif_stable", PCIF, p);
            check32("hold_instr_stable", instrDEC, mem_word(p));
            check32("hold_valid_stable", 32'(validDEC), 32'd1);
            check32("hold_req_skid_full", 32'(imem_req), 32'd0);
        end
        branching_out.hold = 1'b0;
        repeat (8) @(negedge Clock);

        // Flush alone: decode emptied, fetch PC sequence continues.
        @(negedge Clock);
        check32("flush_pre_req", 32'(imem_req), 32'd1);
        a = imem_addr;
        branching_out.flush = 1'b1;
        @(posedge Clock); #1;
        branching_out = '0;
        @(negedge Clock);
        check32("flush_valid", 32'(validDEC), 32'd0);
        check32("flush_req", 32'(imem_req), 32'd1);
        check32("flush_addr_continues", imem_addr, a + 32'd4);
        repeat (8) @(negedge Clock);

        // Reset with a response outstanding, then a late rvalid.
        lat_min = 3; lat_max = 3;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            @(negedge Clock);
            if (imem_req && imem_gnt) found = 1'b1;
        end
        check32("reset_setup_grant", 32'(found), 32'd1);
        @(posedge Clock); #1;
        Reset   = 1'b1;
        gnt_pct = 0;
        @(posedge Clock); #1;
        Reset = 1'b0;
        @(negedge Clock);
        check_reset_outputs("midreset");
        check32("midreset_outstanding", 32'(dut.outstanding_q), 32'd0);
        repeat (3) @(negedge Clock);
        check32("late_rvalid_pending_gone", 32'(mem_q.size()), 32'd0);
        check32("late_rvalid_valid", 32'(validDEC), 32'd0);
        check32("late_rvalid_pcif", PCIF, 32'h0);
        check32("late_rvalid_instr", instrDEC, NOP_INSTR);
        gnt_pct = 100; lat_min = 1; lat_max = 1;
        repeat (10) @(negedge Clock);

        // Randomized traffic.
        gnt_pct = 75; lat_min = 1; lat_max = 3;
        hold_left = 0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge Clock); #1;
            branching_out = '0;
            r = $urandom_range(99, 0);
            if (hold_left > 0) begin
                branching_out.hold = 1'b1;
                hold_left--;
            end else if (r < 12) begin
                hold_left = int'($urandom_range(3, 0));
                branching_out.hold = 1'b1;
            end
            if (r >= 90 && r < 93) begin
                branching_out.branch    = 1'b1;
                branching_out.bypass    = ($urandom_range(3, 0) == 0);
                branching_out.PCcurrent = $urandom;
                branching_out.PCnext    = $urandom;
                hold_left = 0;
            end else if (r >= 93 && r < 96) begin
                branching_out.bypass = 1'b1;
                branching_out.PCnext = $urandom;
                branching_out.flush  = $urandom_range(1, 0) == 1;
                hold_left = 0;
            end else if (r >= 96) begin
                branching_out.flush = 1'b1;
                hold_left = 0;
            end
        end
        @(posedge Clock); #1;
        branching_out = '0;
        repeat (20) @(negedge Clock);

        checks++;
        if (delivered < 500) begin
            errors++;
            $display("FAIL delivered_count: got %0d instructions, required at least 500", delivered);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
